// File: rtl/div_tc_32_16_seq_pkg.sv
// Shared definitions for the sequential signed 32/16 divider: sizes, state
// encoding, the divide-by-zero quotient and the full-adder cell helpers.
`timescale 1ns/1ps
package div_tc_32_16_seq_pkg;

    localparam int DW_DEF = 32;
    localparam int VW_DEF = 16;
    localparam int CNT_W  = $clog2(DW_DEF);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [DW_DEF-1:0] DBZ_QUOT = {DW_DEF{1'b1}};

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (a & ci) | (b & ci);
    endfunction

    // Full adder cell: returns {carry_out, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
        return {fa_carry(a, b, ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/div_tc_32_16_seq_step.sv
// One restoring division step: trial-subtract the divisor magnitude from the
// shifted partial remainder with a ripple of full adders, keep it if no borrow.
`timescale 1ns/1ps
module div_step
    import div_tc_32_16_seq_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   rem_in,
    input  logic [VW:0]   dvs,
    output logic [VW-1:0] rem_out,
    output logic          q_bit
);

    logic [VW:0]   carry_s;
    logic [VW-1:0] diff_s;

    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < VW; i++) begin : g_fa
        assign {carry_s[i+1], diff_s[i]} = fa(rem_in[i], ~dvs[i], carry_s[i]);
    end

    // The top difference bit is always zero when kept, so only its carry matters
    assign q_bit   = fa_carry(rem_in[VW], ~dvs[VW], carry_s[VW]);
    assign rem_out = q_bit ? diff_s : rem_in[VW-1:0];

endmodule

// File: rtl/div_tc_32_16_seq.sv
// Iterative signed divider, 32-bit dividend by 16-bit divisor: restoring
// division on magnitudes, one quotient bit per clock, sign fix-up at the end.
`timescale 1ns/1ps
module div_tc_32_16_seq
    import div_tc_32_16_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);

    localparam int CW = $clog2(DW);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW:0]   dvs_q, dvs_d;
    logic [VW-1:0] raw_lo_q, raw_lo_d;
    logic          quo_neg_q, quo_neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic          op_dbz_q, op_dbz_d;
    logic          op_ovf_q, op_ovf_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;

    logic [VW:0]   step_rem_in_s;
    logic [VW-1:0] step_rem_out_s;
    logic          step_qbit_s;
    logic [DW-1:0] dvd_mag_s;
    logic [VW-1:0] dvs_mag_s;

    // The dividend register doubles as the quotient shift register
    assign step_rem_in_s = {rem_q, dvd_q[DW-1]};

    div_step #(.VW(VW)) u_step (
        .rem_in  (step_rem_in_s),
        .dvs     (dvs_q),
        .rem_out (step_rem_out_s),
        .q_bit   (step_qbit_s)
    );

    // Unsigned magnitudes: -2^31 and -2^15 map to their exact unsigned values
    assign dvd_mag_s = dividend[DW-1] ? (-dividend) : dividend;
    assign dvs_mag_s = divisor[VW-1]  ? (-divisor)  : divisor;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

    // Next-state and datapath control for accept, iterate and sign fix-up
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        raw_lo_d    = raw_lo_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        op_dbz_d    = op_dbz_q;
        op_ovf_d    = op_ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CALC;
                    cnt_d     = CW'(DW - 1);
                    dvd_d     = dvd_mag_s;
                    rem_d     = {VW{1'b0}};
                    dvs_d     = {1'b0, dvs_mag_s};
                    raw_lo_d  = dividend[VW-1:0];
                    quo_neg_d = dividend[DW-1] ^ divisor[VW-1];
                    rem_neg_d = dividend[DW-1];
                    op_dbz_d  = (divisor == {VW{1'b0}});
                    op_ovf_d  = (dividend == {1'b1, {(DW-1){1'b0}}}) &&
                                (divisor == {VW{1'b1}});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                dvd_d = {dvd_q[DW-2:0], step_qbit_s};
                rem_d = step_rem_out_s;
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                dbz_d       = op_dbz_q;
                ovf_d       = op_ovf_q;
                if (op_dbz_q) begin
                    quotient_d  = DW'(DBZ_QUOT);
                    remainder_d = raw_lo_q;
                end else begin
                    quotient_d  = quo_neg_q ? (-dvd_q) : dvd_q;
                    remainder_d = rem_neg_q ? (-rem_q) : rem_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            dvd_q       <= {DW{1'b0}};
            rem_q       <= {VW{1'b0}};
            dvs_q       <= {(VW+1){1'b0}};
            raw_lo_q    <= {VW{1'b0}};
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            op_dbz_q    <= 1'b0;
            op_ovf_q    <= 1'b0;
            quotient_q  <= {DW{1'b0}};
            remainder_q <= {VW{1'b0}};
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            raw_lo_q    <= raw_lo_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            op_dbz_q    <= op_dbz_d;
            op_ovf_q    <= op_ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_div_tc_32_16_seq.sv
// Bench for div_tc_32_16_seq: directed vector table, abort/ignore sequences and
// randomized operands checked against a plain-arithmetic division model.
`timescale 1ns/1ps
module tb_div_tc_32_16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        dbz;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    localparam int LAT = 33;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[10];

    div_tc_32_16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Signed division truncating toward zero, with the documented flag overrides
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic z, output logic o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        if (sb == 64'sd0) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
            z = 1'b1;
            o = 1'b0;
        end else begin
            q = 32'(sa / sb);
            r = 16'(sa % sb);
            z = 1'b0;
            o = (sa == -64'sd2147483648) && (sb == -64'sd1);
        end
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is seen
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int lat);
        chk("in_ready_before_start", {31'd0, in_ready}, 32'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 16'h0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          n;
        int          pulses;
        logic [31:0] eq, a;
        logic [15:0] er, b;
        logic        ez, eo;
        longint      sa, sb, sq, sr;

        vecs[0] = '{32'd100,       16'd7,      32'd14,        16'd2,      1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FF9C, 16'd7,      32'hFFFF_FFF2, 16'hFFFE,   1'b0, 1'b0};
        vecs[2] = '{32'd100,       16'hFFF9,   32'hFFFF_FFF2, 16'h0002,   1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 16'hFFFF,   32'h8000_0000, 16'h0000,   1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 16'h8000,   32'h0001_0000, 16'h0000,   1'b0, 1'b0};
        vecs[5] = '{32'd12345,     16'd0,      32'hFFFF_FFFF, 16'h3039,   1'b1, 1'b0};
        vecs[6] = '{32'd0,         16'd5,      32'd0,         16'd0,      1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFF9, 16'd7,      32'hFFFF_FFFF, 16'h0000,   1'b0, 1'b0};
        vecs[8] = '{32'h7FFF_FFFF, 16'h7FFF,   32'h0001_0002, 16'h0001,   1'b0, 1'b0};
        vecs[9] = '{32'hFFFF_8000, 16'h8000,   32'h0000_0001, 16'h0000,   1'b0, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_quotient",  quotient,           32'd0);
        chk("reset_remainder", {16'd0, remainder}, 32'd0);
        chk("reset_dbz",       {31'd0, dbz},       32'd0);
        chk("reset_ovf",       {31'd0, ovf},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, lat);
            chk($sformatf("vec%0d_latency", i),   lat,                    LAT);
            chk($sformatf("vec%0d_quotient", i),  quotient,               vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), {16'd0, remainder},     {16'd0, vecs[i].r});
            chk($sformatf("vec%0d_dbz", i),       {31'd0, dbz},           {31'd0, vecs[i].z});
            chk($sformatf("vec%0d_ovf", i),       {31'd0, ovf},           {31'd0, vecs[i].o});
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},      32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_end", i), {31'd0, out_valid},     32'd0);
            chk($sformatf("vec%0d_hold_q", i),    quotient,               vecs[i].q);
            repeat (2) @(negedge clk);
        end

        // start raised while an operation is in progress must be ignored
        dividend = 32'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (n == 9) begin
                start    = 1'b1;
                dividend = 32'd999;
                divisor  = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("ignore_latency",   n,                  LAT);
        chk("ignore_quotient",  quotient,           32'd14);
        chk("ignore_remainder", {16'd0, remainder}, 32'd2);
        @(negedge clk);
        pulses = 0;
        repeat (40) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        chk("ignore_no_second_op", pulses, 0);

        // reset in the middle of an operation aborts it
        dividend = 32'd12345;
        divisor  = 16'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 20; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_quotient",  quotient,           32'd0);
        chk("abort_remainder", {16'd0, remainder}, 32'd0);
        chk("abort_dbz",       {31'd0, dbz},       32'd0);
        chk("abort_ovf",       {31'd0, ovf},       32'd0);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_no_out_valid", pulses, 0);

        // randomized operands, some issued back-to-back
        for (int t = 0; t < 1500; t++) begin
            case ($urandom_range(7, 0))
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                2:       b = 16'h8000;
                3:       b = 16'h0001;
                4:       b = 16'($urandom_range(15, 1));
                default: b = 16'($urandom());
            endcase
            case ($urandom_range(9, 0))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                2:       a = 32'($signed(16'($urandom())));
                default: a = $urandom();
            endcase
            model(a, b, eq, er, ez, eo);
            run_op(a, b, lat);
            chk("rand_latency",   lat,                LAT);
            chk("rand_quotient",  quotient,           eq);
            chk("rand_remainder", {16'd0, remainder}, {16'd0, er});
            chk("rand_dbz",       {31'd0, dbz},       {31'd0, ez});
            chk("rand_ovf",       {31'd0, ovf},       {31'd0, eo});
            if (!ez && !eo) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = longint'($signed(quotient));
                sr = longint'($signed(remainder));
                chk("rand_identity", {31'd0, (sq * sb + sr) == sa}, 32'd1);
                chk("rand_rem_mag",
                    {31'd0, ((sr < 0) ? -sr : sr) < ((sb < 0) ? -sb : sb)}, 32'd1);
                chk("rand_rem_sign", {31'd0, (sr == 0) || ((sr < 0) == (sa < 0))}, 32'd1);
            end
            if ($urandom_range(1, 0) == 0) begin
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
